// File: rtl/moo_do_unpack_if.sv
// moo_do_unpack_if: 32-bit word stream from the unpack stage to the host bus
//   dout      word data, big-endian within the block
//   dout_be   byte enables, bit 3 covers dout[31:24]
//   dout_vld  word valid
//   dout_lst  final word of the final block
//   dout_rdy  downstream accepts the word
interface moo_do_unpack_if;
   logic [31:0] dout;
   logic [3:0]  dout_be;
   logic        dout_vld;
   logic        dout_lst;
   logic        dout_rdy;
   modport master (output dout, dout_be, dout_vld, dout_lst, input dout_rdy);
   modport slave  (input dout, dout_be, dout_vld, dout_lst, output dout_rdy);
endinterface

// File: rtl/moo_do_unpack.sv
// moo_do_unpack: captures one 128-bit moo result and streams it as masked 32-bit words
//   clk, rst_n          clock, async active-low reset
//   clr_core            sync clear of the whole stage
//   do_sel              0 ecb_do, 1 xfb_do, 2 mac_do, 3 zero block
//   ecb_do/xfb_do/mac_do  candidate result blocks
//   moo_do_vld/rdy      block handshake with moo
//   blk_lst, blk_bytes  final-block flag and its byte count (0 means 16)
//   blk_cnt             blocks fully delivered, wraps
//   dout_if             outgoing word stream
module moo_do_unpack (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_core,
   input  logic [1:0]    do_sel,
   input  logic [127:0]  ecb_do,
   input  logic [127:0]  xfb_do,
   input  logic [127:0]  mac_do,
   input  logic          moo_do_vld,
   output logic          moo_do_rdy,
   input  logic          blk_lst,
   input  logic [3:0]    blk_bytes,
   output logic [15:0]   blk_cnt,
   moo_do_unpack_if.master dout_if
);
   typedef enum logic {IDLE, SEND} state_t;
   state_t state, state_d;
   logic [127:0] blk_q, blk_sel;
   logic [1:0]   wptr, nw_m1;
   logic [3:0]   lmask, bm1, be;
   logic [31:0]  word;
   logic         lst_q, send, fin, acc, done, cap;
   // bytes-minus-one: 0 wraps to 15, so the 16-byte case falls out naturally
   assign bm1 = blk_bytes - 4'd1;
   always_comb begin
      blk_sel    = do_sel == 2'd0 ? ecb_do : do_sel == 2'd1 ? xfb_do : do_sel == 2'd2 ? mac_do : '0;
      send       = state == SEND;
      fin        = wptr == nw_m1;
      acc        = send & dout_if.dout_rdy;
      done       = acc & fin;
      // combinational through dout_rdy so a new block loads on the final-word accept
      moo_do_rdy = ~clr_core & (~send | done);
      cap        = moo_do_vld & moo_do_rdy;
      word       = wptr == 2'd0 ? blk_q[127:96] : wptr == 2'd1 ? blk_q[95:64] :
                   wptr == 2'd2 ? blk_q[63:32] : blk_q[31:0];
      be         = send ? (fin ? lmask : 4'hF) : 4'h0;
   end
   always_comb begin
      state_d = state;
      if (clr_core) state_d = IDLE;
      else if (cap) state_d = SEND;
      else if (done) state_d = IDLE;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_d;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         blk_q   <= '0;
         wptr    <= '0;
         nw_m1   <= '0;
         lmask   <= '0;
         lst_q   <= 1'b0;
         blk_cnt <= '0;
      end else if (clr_core) begin
         blk_q   <= '0;
         wptr    <= '0;
         nw_m1   <= '0;
         lmask   <= '0;
         lst_q   <= 1'b0;
         blk_cnt <= '0;
      end else begin
         if (done) blk_cnt <= blk_cnt + 16'd1;
         if (cap) begin
            blk_q <= blk_sel;
            lst_q <= blk_lst;
            wptr  <= '0;
            nw_m1 <= blk_lst ? bm1[3:2] : 2'd3;
            // top (bm1[1:0]+1) byte lanes enabled on the final word
            lmask <= blk_lst ? 4'hF << (2'd3 - bm1[1:0]) : 4'hF;
         end else if (acc & ~fin) wptr <= wptr + 2'd1;
      end
   assign dout_if.dout     = word & {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   assign dout_if.dout_be  = be;
   assign dout_if.dout_vld = send;
   assign dout_if.dout_lst = send & lst_q & fin;
endmodule

// File: tb/tb_moo_do_unpack.sv
// tb_moo_do_unpack: directed checks of capture, word order, masking, backpressure and clear
module tb_moo_do_unpack;
   localparam logic [127:0] D  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [127:0] M1 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
   localparam logic [127:0] M2 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
   logic         clk = 1'b0, rst_n = 1'b0, clr_core = 1'b0;
   logic [1:0]   do_sel = '0;
   logic [127:0] ecb_do = '0, xfb_do = '0, mac_do = '0;
   logic         moo_do_vld = 1'b0, blk_lst = 1'b0, moo_do_rdy;
   logic [3:0]   blk_bytes = '0;
   logic [15:0]  blk_cnt;
   int           n_vec = 0, n_err = 0;
   moo_do_unpack_if dif();
   always #5 clk = ~clk;
   moo_do_unpack dut (
      .clk(clk), .rst_n(rst_n), .clr_core(clr_core), .do_sel(do_sel),
      .ecb_do(ecb_do), .xfb_do(xfb_do), .mac_do(mac_do),
      .moo_do_vld(moo_do_vld), .moo_do_rdy(moo_do_rdy),
      .blk_lst(blk_lst), .blk_bytes(blk_bytes), .blk_cnt(blk_cnt),
      .dout_if(dif)
   );
   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic chk_word(input string tag, input logic [31:0] d, input logic [3:0] be, input logic lst);
      chk({tag, "_vld"}, dif.dout_vld, 1'b1);
      chk({tag, "_d"}, dif.dout, d);
      chk({tag, "_be"}, dif.dout_be, be);
      chk({tag, "_lst"}, dif.dout_lst, lst);
   endtask
   task automatic chk_idle(input string tag, input logic [15:0] cnt);
      chk({tag, "_vld"}, dif.dout_vld, 1'b0);
      chk({tag, "_d"}, dif.dout, 32'h0);
      chk({tag, "_be"}, dif.dout_be, 4'h0);
      chk({tag, "_rdy"}, moo_do_rdy, 1'b1);
      chk({tag, "_cnt"}, blk_cnt, cnt);
   endtask
   function automatic logic [31:0] wd(input logic [127:0] b, input int k);
      return b[127 - 32*k -: 32];
   endfunction
   task automatic cap_blk(input logic [1:0] sel, input logic lst, input logic [3:0] nb);
      @(negedge clk);
      do_sel = sel; ecb_do = D; xfb_do = D; mac_do = D;
      blk_lst = lst; blk_bytes = nb; moo_do_vld = 1'b1;
      #1 chk("cap_rdy", moo_do_rdy, 1'b1);
   endtask
   initial begin
      dif.dout_rdy = 1'b1;
      repeat (2) @(negedge clk);
      #1 chk_idle("in_rst", 16'd0);
      rst_n = 1'b1;
      @(negedge clk);
      #1 chk_idle("idle", 16'd0);
      // full ECB block
      cap_blk(2'd0, 1'b0, 4'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         moo_do_vld = 1'b0; ecb_do = '0; xfb_do = '0; mac_do = '0;
         #1 chk_word($sformatf("ecb_w%0d", k), wd(D, k), 4'hF, 1'b0);
         chk($sformatf("ecb_rdy%0d", k), moo_do_rdy, k == 3);
      end
      @(negedge clk);
      #1 chk_idle("ecb_end", 16'd1);
      // partial final block, 6 bytes, from feedback source; later input changes ignored
      cap_blk(2'd1, 1'b1, 4'd6);
      @(negedge clk);
      moo_do_vld = 1'b0; do_sel = 2'd0; blk_lst = 1'b0; blk_bytes = 4'd9; xfb_do = '0;
      #1 chk_word("part_w0", 32'h00112233, 4'hF, 1'b0);
      @(negedge clk);
      #1 chk_word("part_w1", 32'h44550000, 4'hC, 1'b1);
      @(negedge clk);
      #1 chk_idle("part_end", 16'd2);
      // backpressure on word 1
      cap_blk(2'd0, 1'b0, 4'd0);
      @(negedge clk);
      moo_do_vld = 1'b0;
      #1 chk_word("bp_w0", 32'h00112233, 4'hF, 1'b0);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         dif.dout_rdy = 1'b0; moo_do_vld = 1'b1;
         #1 chk_word($sformatf("bp_hold%0d", j), 32'h44556677, 4'hF, 1'b0);
         chk($sformatf("bp_rdy%0d", j), moo_do_rdy, 1'b0);
      end
      @(negedge clk);
      dif.dout_rdy = 1'b1; moo_do_vld = 1'b0;
      #1 chk_word("bp_w1", 32'h44556677, 4'hF, 1'b0);
      @(negedge clk);
      #1 chk_word("bp_w2", 32'h8899AABB, 4'hF, 1'b0);
      @(negedge clk);
      #1 chk_word("bp_w3", 32'hCCDDEEFF, 4'hF, 1'b0);
      @(negedge clk);
      #1 chk_idle("bp_end", 16'd3);
      // back-to-back MAC blocks
      @(negedge clk);
      do_sel = 2'd2; mac_do = M1; blk_lst = 1'b0; moo_do_vld = 1'b1;
      #1 chk("b2b_cap", moo_do_rdy, 1'b1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 0) mac_do = M2;
         if (i == 4) moo_do_vld = 1'b0;
         #1 chk_word($sformatf("b2b_w%0d", i), i < 4 ? wd(M1, i) : wd(M2, i - 4), 4'hF, 1'b0);
         chk($sformatf("b2b_rdy%0d", i), moo_do_rdy, i == 3 || i == 7);
      end
      @(negedge clk);
      #1 chk_idle("b2b_end", 16'd5);
      // reserved select captures zero; 1-byte final block
      cap_blk(2'd3, 1'b1, 4'd1);
      @(negedge clk);
      moo_do_vld = 1'b0;
      #1 chk_word("rsv_w0", 32'h0, 4'h8, 1'b1);
      @(negedge clk);
      #1 chk_idle("rsv_end", 16'd6);
      // clear mid-block
      cap_blk(2'd0, 1'b0, 4'd0);
      @(negedge clk);
      moo_do_vld = 1'b0;
      #1 chk_word("clr_w0", 32'h00112233, 4'hF, 1'b0);
      @(negedge clk);
      #1 chk_word("clr_w1", 32'h44556677, 4'hF, 1'b0);
      @(negedge clk);
      clr_core = 1'b1; moo_do_vld = 1'b1;
      #1 chk("clr_rdy", moo_do_rdy, 1'b0);
      @(negedge clk);
      clr_core = 1'b0; moo_do_vld = 1'b0;
      #1 chk_idle("clr_after", 16'd0);
      // 16-byte final block encoded as blk_bytes = 0
      cap_blk(2'd0, 1'b1, 4'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         moo_do_vld = 1'b0;
         #1 chk_word($sformatf("l16_w%0d", k), wd(D, k), 4'hF, k == 3);
      end
      @(negedge clk);
      #1 chk_idle("l16_end", 16'd1);
      // async reset mid-block drops it
      cap_blk(2'd0, 1'b0, 4'd0);
      @(negedge clk);
      moo_do_vld = 1'b0;
      #1 chk_word("ar_w0", 32'h00112233, 4'hF, 1'b0);
      #1 rst_n = 1'b0;
      #1 chk_idle("ar_rst", 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/moo_do_unpack.md
# moo_do_unpack

Output stage of the ARIA mode-of-operation core. It sits directly downstream of `moo`. It captures one 128-bit result block per `moo_do_vld`/`moo_do_rdy` handshake, choosing between ECB, feedback or MAC output. It then serializes the block into big-endian 32-bit words on a valid/ready stream to the host bus, zero-masks the partial final block, and suppresses words that lie entirely past the message end.

## Interface
Parameters:
- none; data widths are fixed (128-bit block, 32-bit word).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr_core`  in  1  synchronous clear, same scope as the core's other stages.
- `do_sel`  in  2  source select: 0 = `ecb_do`, 1 = `xfb_do`, 2 = `mac_do`, 3 = reserved (captures zero).
- `ecb_do`  in  128  ECB result from `moo`.
- `xfb_do`  in  128  feedback-mode (CBC/CFB/OFB/CTR) result from `moo`.
- `mac_do`  in  128  MAC/tag result from `moo`.
- `moo_do_vld`  in  1  `moo` result valid.
- `moo_do_rdy`  out  1  this block accepts a result (drives `moo`'s `moo_do_rdy`).
- `blk_lst`  in  1  the block being handed over is the final block of the message.
- `blk_bytes`  in  4  valid bytes in the final block; 0 means 16. This is `size_msg[3:0]`.
- `dout`  out  32  output word.
- `dout_be`  out  4  byte enables for `dout`; bit 3 is `dout[31:24]`.
- `dout_vld`  out  1  `dout` valid.
- `dout_lst`  out  1  final word of the final block.
- `dout_rdy`  in  1  downstream accepts the word.
- `blk_cnt`  out  16  blocks fully delivered since reset or clear; wraps.

## Operation
- **State machine:**
  - `IDLE`: buffer empty.
  - `SEND`: buffer holds a block; `wptr[1:0]` indexes the current word.
- **Capture:**
  - `cap = moo_do_vld & moo_do_rdy`.
  - On `cap`, latch the `do_sel`-selected block into `buf`, latch `blk_lst`, and latch `nw`/`lb`.
  - `nw` (words to emit): for a last block, `nw = ceil(B/4)` with `B = (blk_bytes==0) ? 16 : blk_bytes`; otherwise `nw = 4`.
  - `lb` (valid bytes in the final word): for a last block, `lb = B - 4*(nw-1)`; otherwise `lb = 4`.
  - Set `wptr = 0` and go to `SEND`.
- **Word order:** word k is `buf[127-32k -: 32]`.
- **Output in `SEND`:**
  - `dout_vld = 1`.
  - `dout` = word `wptr`, with bytes outside `dout_be` forced to 0.
  - `dout_be` = 4'hF, except on word `nw-1` of a last block, where it is the top `lb` bits set (1→8, 2→C, 3→E, 4→F).
  - `dout_lst` = latched `blk_lst & (wptr == nw-1)`.
- **Advance:** on `dout_vld & dout_rdy`:
  - If `wptr != nw-1`: `wptr` increments.
  - Otherwise (final word): `blk_cnt` increments, and either the state goes to `IDLE` or, if `cap` occurs the same cycle, a new block loads (state stays `SEND`, `wptr = 0`).
- **Ready:** `moo_do_rdy = ~clr_core & (state==IDLE | (dout_vld & dout_rdy & wptr==nw-1))`. This is combinational from `dout_rdy`, which is intentional so back-to-back blocks have no bubble.
- **Hold rule:** `dout`, `dout_be` and `dout_lst` stay stable while `dout_vld & ~dout_rdy`. Changes on `do_sel`, `blk_lst`, `blk_bytes` or the data inputs outside a `cap` cycle have no effect.
- **`clr_core`:** the next state is `IDLE`. `buf`, `wptr` and `blk_cnt` clear, and any partially sent block is discarded. `clr_core` takes priority over a simultaneous capture or advance.
- **`do_sel == 3`:** captures an all-zero block; the handshake is otherwise normal.

## Timing
- **Reset (`rst_n` low, asynchronous):**
  - State `IDLE`, `buf = 0`, `wptr = 0`, `blk_cnt = 0`.
  - Outputs: `dout = 0`, `dout_be = 0`, `dout_vld = 0`, `dout_lst = 0`, `moo_do_rdy = 1`.
  - A reset mid-block drops the block.
- **Latency:** `cap` in cycle T puts word 0 on `dout` with `dout_vld = 1` in T+1.
- **Throughput:** with `dout_rdy` held high, one word per cycle. A full block takes 4 cycles; a final block of B bytes takes `ceil(B/4)` cycles.
- **Back-to-back:** the next block's capture coincides with the final-word accept, so its word 0 appears the following cycle and `dout_vld` stays continuously high.
- **Outputs when not in `SEND`:** `dout_be`, `dout` and `dout_lst` are 0.
- **`blk_cnt`:** updates in the cycle after the final-word accept and wraps 0xFFFF → 0.

## Test plan
- **Reset/idle:** release `rst_n` with no traffic → `moo_do_rdy=1`, `dout_vld=0`, `dout=0`, `blk_cnt=0`.
- **Full ECB block:** `do_sel=0`, `ecb_do=128'h00112233_44556677_8899AABB_CCDDEEFF`, `blk_lst=0`, `dout_rdy=1` → words 00112233, 44556677, 8899AABB, CCDDEEFF in cycles T+1..T+4, all with `be=F` and `dout_lst=0`; `blk_cnt=1`.
- **Partial last block:** `do_sel=1`, `blk_lst=1`, `blk_bytes=6`, same data → two words: 00112233 with `be=F`, then 44550000 with `be=C` and `dout_lst=1`; state returns to `IDLE`.
- **Backpressure:** hold `dout_rdy=0` for 3 cycles on word 1 → `dout` stays 44556677 and `moo_do_rdy=0` throughout; the sequence resumes unchanged when `dout_rdy` rises.
- **Back-to-back:** two MAC blocks (`do_sel=2`) with `moo_do_vld` held high and `dout_rdy=1` → 8 consecutive valid words with no gap; the second capture coincides with the first block's word 3; `blk_cnt=2`.
- **Clear mid-block:** assert `clr_core` after word 1 is accepted → next cycle `dout_vld=0` and `blk_cnt=0`; the following capture restarts cleanly at word 0; `blk_bytes=0` with `blk_lst=1` emits 4 words, the last with `be=F` and `dout_lst=1`.
